// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the CPU load/store port, the peripheral master port and the data
//   memory port that meet at the data-memory arbiter.
//   Modports:
//     slave  - the arbiter: takes CPU/peripheral requests and memory read data,
//              drives stall/grant/read-data and the memory control signals.
//     master - the surrounding system (CPU, peripheral and memory together).
//   Parameters: AW address width, DW data width.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // CPU load/store port
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  // Peripheral master port
  logic          per_req;
  logic          per_wr;
  logic          per_lock;
  logic [AW-1:0] per_addr;
  logic [DW-1:0] per_wdata;
  logic          per_gnt;
  logic [DW-1:0] per_rdata;
  logic          per_rvalid;
  // Data memory port
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  per_req, per_wr, per_lock, per_addr, per_wdata,
    output per_gnt, per_rdata, per_rvalid,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output per_req, per_wr, per_lock, per_addr, per_wdata,
    input  per_gnt, per_rdata, per_rvalid,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-cycle data memory between the CPU load/store port and a
//   single peripheral master (UART/DMA). The CPU owns the memory by default;
//   the peripheral is served when the CPU is idle, when it has been starved for
//   MAX_WAIT cycles, or while it holds a locked burst (up to MAX_BURST grants).
//   cpu_stall freezes the CPU for any cycle in which its access is not served.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-low
//     bus    dmem_arbiter_if.slave: CPU port, peripheral port, memory port
//   Parameters: AW, DW, MAX_WAIT (1..15), MAX_BURST (1..15).
//   Build option: define ARB_RR_EN to replace the fixed-priority/starvation
//   guard with round-robin between contested CPU and peripheral requests.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input logic            clk,
  input logic            reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    S_CPU = 1'b0,
    S_PER = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

  state_t        state;
  state_t        state_nx;
  logic [3:0]    wait_cnt;
  logic [3:0]    burst_cnt;
  logic          cpu_act;
  logic          cpu_srv;
  logic          per_srv;
  logic          per_win;
  logic [DW-1:0] rdata_q;
  logic          rvalid_q;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] wdata_mux;

  assign cpu_act = bus.cpu_rd | bus.cpu_wr;

  // Whether the peripheral takes the memory in S_CPU this cycle.
`ifdef ARB_RR_EN
  // last_per = 1 when the most recent contested grant went to the peripheral.
  logic last_per;
  always_comb per_win = bus.per_req & (~cpu_act | ~last_per);
`else
  always_comb per_win = bus.per_req & (~cpu_act | (wait_cnt == MAX_WAIT_C));
`endif

  // Next state and who is served. Nothing is served while reset is low.
  always_comb begin
    state_nx = state;
    cpu_srv  = 1'b0;
    per_srv  = 1'b0;
    if (reset) begin
      case (state)
        S_CPU: begin
          if (per_win) begin
            per_srv = 1'b1;
            // A one-grant burst limit means the lock can never extend.
            if (bus.per_lock && (MAX_BURST_C != 4'd1)) state_nx = S_PER;
          end else begin
            cpu_srv = cpu_act;
          end
        end
        S_PER: begin
          if (bus.per_req) begin
            per_srv = 1'b1;
            // burst_cnt counts grants already made; this grant is one more.
            if (!bus.per_lock || (burst_cnt + 4'd1 == MAX_BURST_C)) state_nx = S_CPU;
          end else begin
            cpu_srv  = cpu_act;
            state_nx = S_CPU;
          end
        end
        default: state_nx = S_CPU;
      endcase
    end
  end

  assign addr_mux  = per_srv ? bus.per_addr  : bus.cpu_addr;
  assign wdata_mux = per_srv ? bus.per_wdata : bus.cpu_wdata;

  assign bus.mem_rd     = (cpu_srv & bus.cpu_rd) | (per_srv & ~bus.per_wr);
  assign bus.mem_wr     = (cpu_srv & bus.cpu_wr) | (per_srv &  bus.per_wr);
  assign bus.mem_addr   = addr_mux;
  assign bus.mem_wdata  = wdata_mux;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = per_srv & cpu_act;
  assign bus.per_gnt    = per_srv;
  assign bus.per_rdata  = rdata_q;
  assign bus.per_rvalid = rvalid_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_CPU;
      wait_cnt  <= 4'd0;
      burst_cnt <= 4'd0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
`ifdef ARB_RR_EN
      last_per  <= 1'b0;
`endif
    end else begin
      state <= state_nx;

      if (per_srv)                   wait_cnt <= 4'd0;
      else if (bus.per_req) begin
        if (wait_cnt != MAX_WAIT_C)  wait_cnt <= wait_cnt + 4'd1;
      end else                       wait_cnt <= 4'd0;

      // A grant from S_CPU is the first of a potential burst.
      if (state == S_CPU)            burst_cnt <= {3'b000, per_srv};
      else if (per_srv)              burst_cnt <= burst_cnt + 4'd1;

      rvalid_q <= per_srv & ~bus.per_wr;
      if (per_srv & ~bus.per_wr)     rdata_q <= bus.mem_rdata;

`ifdef ARB_RR_EN
      if ((state == S_CPU) && cpu_act && bus.per_req) last_per <= per_srv;
`endif
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Data memory: 64 words, combinational read, write at the clock edge.
  logic [31:0] mem [64] = '{default: 32'h0};
  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) if (bus.mem_wr) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;

  // Reference model state (counts of grants and lost cycles, expected memory).
  logic [31:0] shadow [64] = '{default: 32'h0};
  int          lost = 0;
  int          blen = 0;
  bit          last_cpu = 1'b1;
  bit          m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  bit          m_pw = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic        cap_gnt, cap_stall, cap_wr, cap_rvalid;
  logic [31:0] cap_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_n, input logic crd, input logic cwr,
                       input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic preq, input logic pwr, input logic plock,
                       input logic [31:0] paddr, input logic [31:0] pwd);
    reset         = rst_n;
    bus.cpu_rd    = crd;
    bus.cpu_wr    = cwr;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.per_req   = preq;
    bus.per_wr    = pwr;
    bus.per_lock  = plock;
    bus.per_addr  = paddr;
    bus.per_wdata = pwd;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cycle();
    bit cact, pw, cs, e_wr, e_rd, locked;
    #3;
    cact   = bus.cpu_rd || bus.cpu_wr;
    locked = (blen > 0);
    if (!reset)      pw = 1'b0;
    else if (locked) pw = bus.per_req;
    else begin
`ifdef ARB_RR_EN
      pw = bus.per_req && (!cact || last_cpu);
`else
      pw = bus.per_req && (!cact || lost >= MAX_WAIT);
`endif
    end
    cs   = reset && !pw && cact;
    e_wr = (cs && bus.cpu_wr) || (pw && bus.per_wr);
    e_rd = (cs && bus.cpu_rd) || (pw && !bus.per_wr);

    cap_gnt = bus.per_gnt; cap_stall = bus.cpu_stall; cap_wr = bus.mem_wr;
    cap_rvalid = bus.per_rvalid; cap_rdata = bus.per_rdata;

    chk("per_gnt",    32'(bus.per_gnt),    32'(pw));
    chk("cpu_stall",  32'(bus.cpu_stall),  32'(pw && cact));
    chk("mem_wr",     32'(bus.mem_wr),     32'(e_wr));
    chk("mem_rd",     32'(bus.mem_rd),     32'(e_rd));
    chk("per_rvalid", 32'(bus.per_rvalid), 32'(m_rvalid));
    if (m_rvalid) chk("per_rdata", bus.per_rdata, m_rdata);
    if (pw || cs) chk("mem_addr", bus.mem_addr, pw ? bus.per_addr : bus.cpu_addr);
    if (e_wr)     chk("mem_wdata", bus.mem_wdata, pw ? bus.per_wdata : bus.cpu_wdata);
    if (cs && bus.cpu_rd) chk("cpu_rdata", bus.cpu_rdata, shadow[bus.cpu_addr[7:2]]);

    @(posedge clk);
    m_pw = pw;
    if (!reset) begin
      lost = 0; blen = 0; last_cpu = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h0;
    end else begin
      m_rvalid = pw && !bus.per_wr;
      if (m_rvalid) m_rdata = shadow[bus.per_addr[7:2]];
      if (e_wr) begin
        if (pw) shadow[bus.per_addr[7:2]] = bus.per_wdata;
        else    shadow[bus.cpu_addr[7:2]] = bus.cpu_wdata;
      end
      if (!locked && cact && bus.per_req) last_cpu = !pw;
      if (pw) begin
        lost = 0;
        if (bus.per_lock) begin
          blen = blen + 1;
          if (blen >= MAX_BURST) blen = 0;
        end else blen = 0;
      end else begin
        blen = 0;
        lost = bus.per_req ? ((lost + 1 > MAX_WAIT) ? MAX_WAIT : lost + 1) : 0;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        rst_n, crd, cwr;
    logic [31:0] caddr, cwd;
    logic        preq, pwr, plock;
    logic [31:0] paddr, pwd;
    logic        egnt, estall, ewr, ervalid;
    logic [31:0] erdata;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 32'h18, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 1'b0, 32'h18, 32'h12345678, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h18, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 1'b0, 32'h14, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D};

    // Initial reset cycle, not checked (registers are unknown before the first edge).
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst_n, tbl[i].crd, tbl[i].cwr, tbl[i].caddr, tbl[i].cwd,
            tbl[i].preq, tbl[i].pwr, tbl[i].plock, tbl[i].paddr, tbl[i].pwd);
      cycle();
      chk($sformatf("tbl%0d gnt", i),    32'(cap_gnt),    32'(tbl[i].egnt));
      chk($sformatf("tbl%0d stall", i),  32'(cap_stall),  32'(tbl[i].estall));
      chk($sformatf("tbl%0d mem_wr", i), 32'(cap_wr),     32'(tbl[i].ewr));
      chk($sformatf("tbl%0d rvalid", i), 32'(cap_rvalid), 32'(tbl[i].ervalid));
      if (tbl[i].ervalid) chk($sformatf("tbl%0d rdata", i), cap_rdata, tbl[i].erdata);
    end

`ifndef ARB_RR_EN
    // Starvation: CPU busy every cycle, peripheral wins on the 5th, CPU on the 6th.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
      cycle();
      chk($sformatf("starve%0d gnt", i),   32'(cap_gnt),   32'(i == MAX_WAIT));
      chk($sformatf("starve%0d stall", i), 32'(cap_stall), 32'(i == MAX_WAIT));
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();
`endif

    // Locked burst from an idle CPU; CPU then tries every cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
      cycle();
      chk($sformatf("burst%0d gnt", i),   32'(cap_gnt),   32'(i < MAX_BURST));
      chk($sformatf("burst%0d stall", i), 32'(cap_stall), 32'(i > 0 && i < MAX_BURST));
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

    // Reset during the third grant of a locked burst.
    for (int i = 0; i < 4; i++) begin
      drive((i == 2) ? 1'b0 : 1'b1, (i == 0) ? 1'b0 : 1'b1, 1'b0, 32'h20, 32'h0,
            1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
      cycle();
      chk($sformatf("rstb%0d gnt", i), 32'(cap_gnt), 32'(i < 2));
    end
    chk("rstb rvalid", 32'(cap_rvalid), 32'h0);
    chk("rstb mem_wr", 32'(cap_wr),     32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle();

`ifdef ARB_RR_EN
    // Both masters contesting every cycle: grants alternate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      cycle();
    end
`endif

    // Randomized traffic checked against the model.
    for (int i = 0; i < 500; i++) begin
      logic        rst_n, crd, cwr, preq, pwr, plock;
      logic [31:0] caddr, cwd, paddr, pwd;
      int          c;
      rst_n = ($urandom_range(0, 49) != 0);
      c     = $urandom_range(0, 2);
      crd   = (c == 1);
      cwr   = (c == 2);
      caddr = {24'h0, 6'($urandom), 2'b00};
      cwd   = $urandom;
      if (bus.per_req && !m_pw) begin
        preq = 1'b1; pwr = bus.per_wr; plock = bus.per_lock;
        paddr = bus.per_addr; pwd = bus.per_wdata;
      end else begin
        preq  = ($urandom_range(0, 2) != 0);
        pwr   = 1'($urandom);
        plock = ($urandom_range(0, 2) != 0);
        paddr = {24'h0, 6'($urandom), 2'b00};
        pwd   = $urandom;
      end
      drive(rst_n, crd, cwr, caddr, cwd, preq, pwr, plock, paddr, pwd);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
